// File: rtl/vga_timing_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_if
//  Description : Bundle between the raster timing generator and its consumers
//                (VRAM read address logic, pixel output stage).
//                pix_en comes from the clock-enable logic; everything else is
//                produced by vga_timing_gen.
//  Signals     :
//    pix_en       1   pixel tick; the raster position advances only when high
//    HSYNC        1   horizontal sync (polarity set by HS_POL of the generator)
//    VSYNC        1   vertical sync (polarity set by VS_POL of the generator)
//    Active       1   current position lies in the visible window
//    col          HW  horizontal position h
//    row          VW  vertical position v
//    line_start   1   one-clk pulse after the tick that makes h = 0
//    frame_start  1   one-clk pulse after the tick that makes (h,v) = (0,0)
//    vblank       1   v is in the vertical blanking region
//    pre_active   1   Active of the look-ahead position
//    pre_col      HW  col of the look-ahead position
//    pre_row      VW  row of the look-ahead position
//  Modports    : master = timing generator, slave = consumer
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_timing_if #(
  parameter int HW = 10,
  parameter int VW = 10
);

  logic          pix_en;
  logic          HSYNC;
  logic          VSYNC;
  logic          Active;
  logic [HW-1:0] col;
  logic [VW-1:0] row;
  logic          line_start;
  logic          frame_start;
  logic          vblank;
  logic          pre_active;
  logic [HW-1:0] pre_col;
  logic [VW-1:0] pre_row;

  modport master (
    input  pix_en,
    output HSYNC,
    output VSYNC,
    output Active,
    output col,
    output row,
    output line_start,
    output frame_start,
    output vblank,
    output pre_active,
    output pre_col,
    output pre_row
  );

  modport slave (
    input  pix_en,
    input  HSYNC,
    input  VSYNC,
    input  Active,
    input  col,
    input  row,
    input  line_start,
    input  frame_start,
    input  vblank,
    input  pre_active,
    input  pre_col,
    input  pre_row
  );

endinterface : vga_timing_if
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parametrised raster timing generator. Keeps a (h,v) position
//                that advances on pix_en ticks and decodes it into sync,
//                visible-window and start-of-line/frame strobes. All outputs
//                are registered and describe the position reached by the most
//                recent tick.
//  Ports       :
//    clk      in   system clock
//    rst      in   synchronous reset, active-high
//    vga_bus  --   vga_timing_if.master (pix_en in; sync/position/strobes out)
//  Build option:
//    VGA_PREFETCH_EN  defined   -> a second position counter runs PREFETCH
//                                  ticks ahead and drives pre_active/pre_col/
//                                  pre_row (address for a PREFETCH-cycle VRAM)
//                     undefined -> pre_* mirror Active/col/row
//  Revision    : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int HW       = 10,
  parameter int VW       = 10,
  parameter int PREFETCH = 2
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vga_bus
);

  // --------------------------------------------------------------------------
  // Timing constants. Every boundary is expressed as an inclusive "last"
  // value so that it always fits in HW/VW bits, even when H_TOTAL itself
  // would not.
  // --------------------------------------------------------------------------
  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] c_H_LAST     = HW'(c_H_TOTAL - 1);
  localparam logic [HW-1:0] c_H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] c_HS_FIRST   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] c_HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [VW-1:0] c_V_LAST     = VW'(c_V_TOTAL - 1);
  localparam logic [VW-1:0] c_V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] c_VS_FIRST   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] c_VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // --------------------------------------------------------------------------
  // Position arithmetic and decode, shared by the main and look-ahead
  // counters so both follow exactly the same wrap rules.
  // --------------------------------------------------------------------------
  function automatic logic [HW-1:0] f_h_next(input logic [HW-1:0] h);
    if (h == c_H_LAST) begin
      f_h_next = '0;
    end else begin
      f_h_next = h + 1'b1;
    end
  endfunction

  // v only moves on the tick that wraps h
  function automatic logic [VW-1:0] f_v_next(input logic [HW-1:0] h,
                                             input logic [VW-1:0] v);
    if (h != c_H_LAST) begin
      f_v_next = v;
    end else if (v == c_V_LAST) begin
      f_v_next = '0;
    end else begin
      f_v_next = v + 1'b1;
    end
  endfunction

  function automatic logic f_hsync(input logic [HW-1:0] h);
    if ((h >= c_HS_FIRST) && (h <= c_HS_LAST)) begin
      f_hsync = HS_POL;
    end else begin
      f_hsync = ~HS_POL;
    end
  endfunction

  function automatic logic f_vsync(input logic [VW-1:0] v);
    if ((v >= c_VS_FIRST) && (v <= c_VS_LAST)) begin
      f_vsync = VS_POL;
    end else begin
      f_vsync = ~VS_POL;
    end
  endfunction

  function automatic logic f_active(input logic [HW-1:0] h,
                                    input logic [VW-1:0] v);
    f_active = (h <= c_H_ACT_LAST) && (v <= c_V_ACT_LAST);
  endfunction

  // --------------------------------------------------------------------------
  // Legal look-ahead is 1..H_ACTIVE-1. This guard has no hardware; an
  // out-of-range setting shows up as g_prefetch_out_of_range in the
  // elaborated hierarchy.
  // --------------------------------------------------------------------------
  if ((PREFETCH < 1) || (PREFETCH >= H_ACTIVE)) begin : g_prefetch_out_of_range
  end

  // --------------------------------------------------------------------------
  // Main position counter and registered outputs
  // --------------------------------------------------------------------------
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_active;
  logic          r_vblank;
  logic          r_line_start;
  logic          r_frame_start;

  logic [HW-1:0] w_h_nxt;
  logic [VW-1:0] w_v_nxt;
  logic          w_h_zero;
  logic          w_v_zero;

  always_comb begin
    w_h_nxt  = f_h_next(r_h);
    w_v_nxt  = f_v_next(r_h, r_v);
    w_h_zero = (r_h == c_H_LAST);
    w_v_zero = (r_v == c_V_LAST);
  end

  // Reset parks the position on the last pixel of the frame so the first
  // tick lands on (0,0) and raises frame_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h           <= c_H_LAST;
      r_v           <= c_V_LAST;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_active      <= 1'b0;
      r_vblank      <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (vga_bus.pix_en) begin
      r_h           <= w_h_nxt;
      r_v           <= w_v_nxt;
      r_hsync       <= f_hsync(w_h_nxt);
      // w_v_nxt differs from r_v only when h wraps, so VSYNC can only
      // change together with h becoming 0.
      r_vsync       <= f_vsync(w_v_nxt);
      r_active      <= f_active(w_h_nxt, w_v_nxt);
      r_vblank      <= (w_v_nxt > c_V_ACT_LAST);
      r_line_start  <= w_h_zero;
      r_frame_start <= w_h_zero && w_v_zero;
    end else begin
      // Levels hold between ticks; the strobes are single-clk wide.
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign vga_bus.HSYNC       = r_hsync;
  assign vga_bus.VSYNC       = r_vsync;
  assign vga_bus.Active      = r_active;
  assign vga_bus.col         = r_h;
  assign vga_bus.row         = r_v;
  assign vga_bus.line_start  = r_line_start;
  assign vga_bus.frame_start = r_frame_start;
  assign vga_bus.vblank      = r_vblank;

`ifdef VGA_PREFETCH_EN
  // --------------------------------------------------------------------------
  // Look-ahead counter: always PREFETCH ticks ahead of (r_h,r_v). From the
  // parked reset position that is PREFETCH-1 ticks past (0,0); since
  // PREFETCH < H_ACTIVE this never crosses a line.
  // --------------------------------------------------------------------------
  localparam logic [HW-1:0] c_PH_RST = HW'(PREFETCH - 1);
  localparam logic [VW-1:0] c_PV_RST = '0;

  logic [HW-1:0] r_ph;
  logic [VW-1:0] r_pv;
  logic          r_pre_active;

  logic [HW-1:0] w_ph_nxt;
  logic [VW-1:0] w_pv_nxt;

  always_comb begin
    w_ph_nxt = f_h_next(r_ph);
    w_pv_nxt = f_v_next(r_ph, r_pv);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ph         <= c_PH_RST;
      r_pv         <= c_PV_RST;
      r_pre_active <= f_active(c_PH_RST, c_PV_RST);
    end else if (vga_bus.pix_en) begin
      r_ph         <= w_ph_nxt;
      r_pv         <= w_pv_nxt;
      r_pre_active <= f_active(w_ph_nxt, w_pv_nxt);
    end
  end

  assign vga_bus.pre_active = r_pre_active;
  assign vga_bus.pre_col    = r_ph;
  assign vga_bus.pre_row    = r_pv;
`else
  // Zero look-ahead: consumers see the current position.
  assign vga_bus.pre_active = r_active;
  assign vga_bus.pre_col    = r_h;
  assign vga_bus.pre_row    = r_v;
`endif

endmodule : vga_timing_gen
`default_nettype wire
